// File: rtl/pll_lock_sequencer.sv
// Sequences the downstream reset around a CC_PLL: pulse steady-lock reset, wait for
// lock, require lock to hold for a programmed time, then release dut_rst_n until lock is lost.
module pll_lock_sequencer #(
  parameter int STDY_RST_CYCLES     = 4,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int CNT_W               = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       pll_locked_stdy,
  input  logic       soft_req,
  output logic       locked_stdy_rst,
  output logic       dut_rst_n,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] relock_count
);

  typedef enum logic [2:0] {
    ST_CLR       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] STDY_LAST    = CNT_W'(STDY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             lock_meta_q, lock_meta_d, lock_s_q, lock_s_d;
  logic             stdy_meta_q, stdy_meta_d, stdy_s_q, stdy_s_d;
  logic             locked_stdy_rst_q, locked_stdy_rst_d;
  logic             dut_rst_n_q, dut_rst_n_d;
  logic             fault_q, fault_d;
  logic [7:0]       relock_count_q, relock_count_d;

  always_comb begin
    lock_meta_d    = pll_locked;
    lock_s_d       = lock_meta_q;
    stdy_meta_d    = pll_locked_stdy;
    stdy_s_d       = stdy_meta_q;
    state_d        = state_q;
    timer_d        = timer_q;
    relock_count_d = relock_count_q;

    if (soft_req) begin
      state_d = ST_CLR;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_CLR: begin
          if (timer_q == STDY_LAST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = ST_STABLE;
            timer_d = '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d = ST_FAULT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_STABLE: begin
          // Any dropout sends us back to WAIT_LOCK with a fresh timeout window.
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_RUN;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s_q || !stdy_s_q) begin
            state_d = ST_CLR;
            timer_d = '0;
            if (relock_count_q != 8'hFF) begin
              relock_count_d = relock_count_q + 8'd1;
            end
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_CLR;
          timer_d = '0;
        end
      endcase
    end

    // Outputs follow the next state so they move on the same edge as the transition.
    locked_stdy_rst_d = (state_d == ST_CLR);
    dut_rst_n_d       = (state_d == ST_RUN);
    fault_d           = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_CLR;
      timer_q           <= '0;
      lock_meta_q       <= 1'b0;
      lock_s_q          <= 1'b0;
      stdy_meta_q       <= 1'b0;
      stdy_s_q          <= 1'b0;
      locked_stdy_rst_q <= 1'b1;
      dut_rst_n_q       <= 1'b0;
      fault_q           <= 1'b0;
      relock_count_q    <= '0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      lock_meta_q       <= lock_meta_d;
      lock_s_q          <= lock_s_d;
      stdy_meta_q       <= stdy_meta_d;
      stdy_s_q          <= stdy_s_d;
      locked_stdy_rst_q <= locked_stdy_rst_d;
      dut_rst_n_q       <= dut_rst_n_d;
      fault_q           <= fault_d;
      relock_count_q    <= relock_count_d;
    end
  end

  assign locked_stdy_rst = locked_stdy_rst_q;
  assign dut_rst_n       = dut_rst_n_q;
  assign fault           = fault_q;
  assign state           = state_q;
  assign relock_count    = relock_count_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed and randomized bench for pll_lock_sequencer; a dwell-time reference model
// predicts every output after each clock edge.
module tb_pll_lock_sequencer;
  localparam int STDY = 4;
  localparam int STAB = 8;
  localparam int TO   = 32;
  localparam int S_CLR = 0, S_WAIT = 1, S_STABLE = 2, S_RUN = 3, S_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_locked_stdy = 1'b0;
  logic       soft_req = 1'b0;
  logic       locked_stdy_rst;
  logic       dut_rst_n;
  logic       fault;
  logic [2:0] state;
  logic [7:0] relock_count;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: phase plus the edge number at which the phase was entered.
  int cyc = 0;
  int m_state = S_CLR;
  int m_entry = 0;
  int m_relock = 0;
  bit lk1, lk2, sk1, sk2;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .STDY_RST_CYCLES    (STDY),
    .LOCK_STABLE_CYCLES (STAB),
    .LOCK_TIMEOUT_CYCLES(TO),
    .CNT_W              (20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .pll_locked_stdy(pll_locked_stdy),
    .soft_req       (soft_req),
    .locked_stdy_rst(locked_stdy_rst),
    .dut_rst_n      (dut_rst_n),
    .fault          (fault),
    .state          (state),
    .relock_count   (relock_count)
  );

  function automatic void m_reset();
    m_state  = S_CLR;
    m_entry  = cyc;
    m_relock = 0;
    lk1 = 1'b0; lk2 = 1'b0; sk1 = 1'b0; sk2 = 1'b0;
  endfunction

  function automatic void m_go(input int s);
    m_state = s;
    m_entry = cyc;
  endfunction

  function automatic void m_edge();
    bit ls;
    bit ss;
    int dwell;
    cyc++;
    if (rst) begin
      m_reset();
      return;
    end
    ls = lk2; ss = sk2;
    lk2 = lk1; lk1 = pll_locked;
    sk2 = sk1; sk1 = pll_locked_stdy;
    dwell = cyc - m_entry;
    if (soft_req) m_go(S_CLR);
    else begin
      case (m_state)
        S_CLR:    if (dwell == STDY) m_go(S_WAIT);
        S_WAIT:   if (ls) m_go(S_STABLE); else if (dwell == TO) m_go(S_FAULT);
        S_STABLE: if (!ls) m_go(S_WAIT); else if (dwell == STAB) m_go(S_RUN);
        S_RUN: begin
          if (!ls || !ss) begin
            if (m_relock < 255) m_relock++;
            m_go(S_CLR);
          end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_model();
    chk("model_state", 32'(state), m_state);
    chk("model_locked_stdy_rst", 32'(locked_stdy_rst), 32'(m_state == S_CLR));
    chk("model_dut_rst_n", 32'(dut_rst_n), 32'(m_state == S_RUN));
    chk("model_fault", 32'(fault), 32'(m_state == S_FAULT));
    chk("model_relock_count", 32'(relock_count), m_relock);
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
    check_model();
  endtask

  task automatic run_until(input logic [2:0] tgt, input string tag);
    for (int k = 0; k < 200 && state !== tgt; k++) tick();
    chk(tag, 32'(state), 32'(tgt));
  endtask

  initial begin
    // Reset state with both lock inputs already high.
    m_reset();
    pll_locked = 1'b1;
    pll_locked_stdy = 1'b1;
    repeat (3) tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_locked_stdy_rst", 32'(locked_stdy_rst), 1);
    chk("rst_dut_rst_n", 32'(dut_rst_n), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_relock_count", 32'(relock_count), 0);

    // Lock already stable: release at edge STDY+1+STAB.
    rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      chk("t1_state", 32'(state), (e < 4) ? 0 : (e == 4) ? 1 : (e < 13) ? 2 : 3);
      chk("t1_locked_stdy_rst", 32'(locked_stdy_rst), 32'(e < 4));
      chk("t1_dut_rst_n", 32'(dut_rst_n), 32'(e >= 13));
    end
    chk("t1_relock_count", 32'(relock_count), 0);

    // Lock never arrives: timeout into FAULT, then soft_req retry.
    rst = 1'b1;
    m_reset();
    pll_locked = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    for (int e = 1; e <= 36; e++) begin
      tick();
      chk("t2_state", 32'(state), (e < 4) ? 0 : (e < 36) ? 1 : 4);
      chk("t2_fault", 32'(fault), 32'(e >= 36));
      chk("t2_dut_rst_n", 32'(dut_rst_n), 0);
    end
    repeat (3) tick();
    chk("t2_fault_hold", 32'(state), 4);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    chk("t2_retry_state", 32'(state), 0);
    chk("t2_retry_fault", 32'(fault), 0);

    // One-cycle dropout at stable count 5 restarts the full stable count.
    pll_locked = 1'b1;
    run_until(3'd2, "t3_reach_stable");
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    chk("t3_still_stable", 32'(state), 2);
    tick();
    chk("t3_back_to_wait", 32'(state), 1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("t3_state", 32'(state), (k == 9) ? 3 : 2);
      chk("t3_dut_rst_n", 32'(dut_rst_n), 32'(k == 9));
    end

    // soft_req and lock loss reach the FSM together: relock_count untouched.
    pll_locked = 1'b0;
    repeat (2) tick();
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    pll_locked = 1'b1;
    chk("t5_state", 32'(state), 0);
    chk("t5_dut_rst_n", 32'(dut_rst_n), 0);
    chk("t5_relock_count", 32'(relock_count), 0);

    // Steady-lock loss in RUN, repeated until the relock counter saturates.
    for (int i = 0; i < 300; i++) begin
      run_until(3'd3, "t4_reach_run");
      pll_locked_stdy = 1'b0;
      repeat (3) tick();
      pll_locked_stdy = 1'b1;
      chk("t4_state", 32'(state), 0);
      chk("t4_dut_rst_n", 32'(dut_rst_n), 0);
      chk("t4_locked_stdy_rst", 32'(locked_stdy_rst), 1);
      chk("t4_relock_count", 32'(relock_count), (i + 1 > 255) ? 255 : i + 1);
    end

    // Asynchronous reset between edges while in STABLE.
    run_until(3'd2, "t6_reach_stable");
    repeat (2) tick();
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    chk("t6_state", 32'(state), 0);
    chk("t6_dut_rst_n", 32'(dut_rst_n), 0);
    chk("t6_locked_stdy_rst", 32'(locked_stdy_rst), 1);
    chk("t6_relock_count", 32'(relock_count), 0);
    chk("t6_fault", 32'(fault), 0);
    repeat (2) tick();
    rst = 1'b0;

    // Randomized lock activity and retry requests against the model.
    for (int n = 0; n < 3000; n++) begin
      if (pll_locked) pll_locked = ($urandom_range(0, 63) != 0);
      else            pll_locked = ($urandom_range(0, 5) == 0);
      if (pll_locked_stdy) pll_locked_stdy = ($urandom_range(0, 95) != 0);
      else                 pll_locked_stdy = ($urandom_range(0, 3) == 0);
      soft_req = ($urandom_range(0, 199) == 0);
      tick();
    end
    soft_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Supervises a CC_PLL instance and sequences reset for the logic clocked by the PLL output, e.g. the LED counter block.
- Clears the PLL steady-lock flag and waits for a lock that holds for a programmable time. Only then releases the downstream reset.
- On loss of lock it re-asserts the downstream reset and restarts the sequence. If lock never arrives, it raises a fault and waits for a retry request.

Parameters:
- STDY_RST_CYCLES, 4: cycles that locked_stdy_rst is held high per sequence (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive cycles of synchronized lock required before release (≥1).
- LOCK_TIMEOUT_CYCLES, 100000: cycles allowed in WAIT_LOCK before FAULT (≥1).
- CNT_W, 20: shared timer width; must hold max(parameters)-1.

Ports:
- clk, in, 1: system clock (PLL reference domain).
- rst, in, 1: asynchronous, active-high reset.
- pll_locked, in, 1: CC_PLL USR_PLL_LOCKED; asynchronous to clk.
- pll_locked_stdy, in, 1: CC_PLL USR_PLL_LOCKED_STDY; asynchronous to clk.
- soft_req, in, 1: single-cycle restart/retry request.
- locked_stdy_rst, out, 1: drives CC_PLL USR_LOCKED_STDY_RST.
- dut_rst_n, out, 1: active-low reset to downstream logic; asserted (0) except in RUN.
- fault, out, 1: lock timeout occurred.
- state, out, 3: current state encoding, for ILA/debug.
- relock_count, out, 8: saturating count of lock losses seen in RUN.

Behaviour:
- Synchronizers:
  - pll_locked and pll_locked_stdy each pass through a 2-flop synchronizer (reset to 0), giving lock_s and stdy_s.
  - Input-to-FSM latency is 2 edges.
- Reset values, while rst is high: state=CLR (0), timer=0, locked_stdy_rst=1, dut_rst_n=0, fault=0, relock_count=0.
- State encoding: CLR=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- All outputs are registered. Each output changes on the same edge as the state transition that implies it.
- CLR:
  - locked_stdy_rst=1; timer increments each edge.
  - When timer==STDY_RST_CYCLES-1: go to WAIT_LOCK and clear timer. locked_stdy_rst is therefore high for exactly STDY_RST_CYCLES edges.
- WAIT_LOCK:
  - If lock_s=1: go to STABLE and clear timer.
  - Otherwise, if timer==LOCK_TIMEOUT_CYCLES-1: go to FAULT and set fault=1.
  - Otherwise increment timer.
- STABLE:
  - If lock_s=0: go to WAIT_LOCK and clear timer. The timeout restarts; it is not cumulative.
  - Otherwise, if timer==LOCK_STABLE_CYCLES-1: go to RUN and set dut_rst_n=1.
  - Otherwise increment timer.
- RUN:
  - dut_rst_n=1.
  - If lock_s=0 or stdy_s=0: go to CLR, set dut_rst_n=0, and increment relock_count (saturate at 255).
  - stdy_s is only checked in RUN.
- FAULT:
  - dut_rst_n=0, fault=1, timer frozen.
  - Leaves only on soft_req.
- soft_req:
  - In any state, soft_req has priority over all other transitions.
  - Next state is CLR with timer cleared, dut_rst_n=0 and fault=0.
  - soft_req does not change relock_count.
  - In CLR, soft_req restarts the CLR hold.
- Simultaneous events in RUN: soft_req together with lock loss leaves relock_count unchanged.
- Reset mid-operation: the state and all outputs return immediately (asynchronously) to their reset values.
- Illegal state encodings 5-7: go to CLR on the next edge.
- Release latency when the lock is already stable: dut_rst_n rises at edge STDY_RST_CYCLES+1+LOCK_STABLE_CYCLES after rst release.

Test Plan:
Bench parameters: STDY_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.
1. pll_locked=pll_locked_stdy=1 from time 0, release rst -> locked_stdy_rst high edges 1-4; state 0→1→2→3; dut_rst_n rises at edge 13; relock_count=0.
2. pll_locked held 0, release rst -> WAIT_LOCK entered after edge 4; fault=1 and state=4 after edge 36; dut_rst_n stays 0; then pulse soft_req -> state=0, fault=0 next edge.
3. In STABLE, drop pll_locked for 1 cycle at stable count 5 -> returns to WAIT_LOCK 2 edges later; full 8-cycle stable count restarts; dut_rst_n rises only after 8 uninterrupted cycles.
4. In RUN, drop pll_locked_stdy -> 2 edges + 1 later dut_rst_n=0, state=0, locked_stdy_rst=1, relock_count=1; repeat 300 times -> relock_count saturates at 255.
5. In RUN, assert soft_req and drop pll_locked so both arrive at the FSM on the same edge -> CLR entered; relock_count unchanged.
6. Assert rst asynchronously mid-STABLE (between edges) -> dut_rst_n=0, locked_stdy_rst=1, state=0, relock_count=0 immediately, without waiting for a clock edge.
